// File: rtl/softmax_seq.sv
// softmax_seq: sequential softmax controller.
// Buffers one input vector (up to DEPTH signed Q4.12 elements) and tracks its
// maximum. It then drives an external reduction unit (RU) in two passes around
// one log2 lookup:
//   pass 1 : RU(max, x_i) -> y_i written back to the buffer, exp term summed
//   log2   : lsum = log2(sum) from the external log2 responder
//   pass 2 : RU(lsum, y_i) -> one result streamed out per element
// Ports:
//   clk, rst                           clock, synchronous active-high reset
//   in_valid/in_ready/in_last/in_data  element input stream
//   out_valid/out_ready/out_last/out_data  result output stream
//   ru_valid_in/ru_en/ru_sel_mult/ru_sel_mux/ru_in_0/ru_in_1  RU request
//   ru_out_0/ru_out_1/ru_valid_out     RU response
//   log2_req/log2_arg/log2_ack/log2_res  log2 request/response
// All outputs are registered. They are decoded from the next state.
module softmax_seq #(
    parameter int unsigned DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_last,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic [15:0] out_data,
    output logic        ru_valid_in,
    output logic        ru_en,
    output logic        ru_sel_mult,
    output logic        ru_sel_mux,
    output logic [15:0] ru_in_0,
    output logic [15:0] ru_in_1,
    input  logic [15:0] ru_out_0,
    input  logic [15:0] ru_out_1,
    input  logic        ru_valid_out,
    output logic        log2_req,
    output logic [15:0] log2_arg,
    input  logic        log2_ack,
    input  logic [15:0] log2_res
);

    localparam int unsigned DW = 16;
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        IDLE, LOAD, S1_ISSUE, S1_WAIT, LOG, S2_ISSUE, S2_WAIT, OUT
    } state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   cnt_q, cnt_d;
    logic [LW-1:0]   len_q, len_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [DW-1:0]   max_q, max_d;
    logic [DW-1:0]   sum_q, sum_d;
    logic [DW-1:0]   lsum_q, lsum_d;
    logic [DW-1:0]   buf_mem [DEPTH];

    logic            wr_en;
    logic [IW-1:0]   wr_idx;
    logic [DW-1:0]   wr_data;
    logic [DW-1:0]   rd_data;
    logic [DW:0]     sum_ext;
    logic            at_last;

    logic            in_ready_d, out_valid_d, out_last_d;
    logic [DW-1:0]   out_data_d;
    logic            ru_valid_in_d, ru_sel_mult_d, ru_sel_mux_d;
    logic [DW-1:0]   ru_in_0_d, ru_in_1_d;
    logic            log2_req_d;
    logic [DW-1:0]   log2_arg_d;

    // Unsigned exp-term accumulation. The carry bit flags saturation.
    assign sum_ext = {1'b0, sum_q} + {1'b0, ru_out_1};
    assign at_last = (LW'(idx_q) == (len_q - LW'(1)));

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        idx_d      = idx_q;
        max_d      = max_q;
        sum_d      = sum_q;
        lsum_d     = lsum_q;
        out_data_d = out_data;
        out_last_d = out_last;
        wr_en      = 1'b0;
        wr_idx     = idx_q;
        wr_data    = ru_out_0;
        case (state_q)
            IDLE, LOAD: begin
                if (in_valid && in_ready) begin
                    wr_en   = 1'b1;
                    wr_idx  = IW'(cnt_q);
                    wr_data = in_data;
                    cnt_d   = cnt_q + LW'(1);
                    if ((cnt_q == '0) || ($signed(in_data) > $signed(max_q))) begin
                        max_d = in_data;
                    end
                    // A full buffer ends the vector even without in_last
                    if (in_last || (cnt_q == LW'(DEPTH - 1))) begin
                        len_d   = cnt_q + LW'(1);
                        idx_d   = '0;
                        sum_d   = '0;
                        state_d = S1_ISSUE;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            S1_ISSUE: state_d = S1_WAIT;
            S1_WAIT: begin
                if (ru_valid_out) begin
                    wr_en   = 1'b1;
                    wr_idx  = idx_q;
                    wr_data = ru_out_0;
                    sum_d   = sum_ext[DW] ? '1 : sum_ext[DW-1:0];
                    if (at_last) begin
                        state_d = LOG;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = S1_ISSUE;
                    end
                end
            end
            LOG: begin
                if (log2_ack) begin
                    lsum_d  = log2_res;
                    idx_d   = '0;
                    state_d = S2_ISSUE;
                end
            end
            S2_ISSUE: state_d = S2_WAIT;
            S2_WAIT: begin
                if (ru_valid_out) begin
                    out_data_d = ru_out_1;
                    out_last_d = at_last;
                    state_d    = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    if (out_last) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = S2_ISSUE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Buffer read for the next issue. It bypasses a write to the same slot in
    // this cycle, which covers a single-element vector that goes straight to issue.
    always_comb begin
        rd_data = buf_mem[idx_d];
        if (wr_en && (wr_idx == idx_d)) begin
            rd_data = wr_data;
        end
    end

    // Registered output decode from the next state
    always_comb begin
        in_ready_d    = (state_d == IDLE) || (state_d == LOAD);
        out_valid_d   = (state_d == OUT);
        log2_req_d    = (state_d == LOG);
        log2_arg_d    = log2_arg;
        ru_valid_in_d = 1'b0;
        ru_sel_mult_d = ru_sel_mult;
        ru_sel_mux_d  = ru_sel_mux;
        ru_in_0_d     = ru_in_0;
        ru_in_1_d     = ru_in_1;
        if (state_d == LOG) begin
            log2_arg_d = sum_d;
        end
        if (state_d == S1_ISSUE) begin
            ru_valid_in_d = 1'b1;
            ru_sel_mult_d = 1'b1;
            ru_sel_mux_d  = 1'b1;
            ru_in_0_d     = max_d;
            ru_in_1_d     = rd_data;
        end else if (state_d == S2_ISSUE) begin
            ru_valid_in_d = 1'b1;
            ru_sel_mult_d = 1'b0;
            ru_sel_mux_d  = 1'b0;
            ru_in_0_d     = lsum_d;
            ru_in_1_d     = rd_data;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            max_q       <= '0;
            sum_q       <= '0;
            lsum_q      <= '0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_data    <= '0;
            ru_valid_in <= 1'b0;
            ru_en       <= 1'b0;
            ru_sel_mult <= 1'b0;
            ru_sel_mux  <= 1'b0;
            ru_in_0     <= '0;
            ru_in_1     <= '0;
            log2_req    <= 1'b0;
            log2_arg    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            max_q       <= max_d;
            sum_q       <= sum_d;
            lsum_q      <= lsum_d;
            in_ready    <= in_ready_d;
            out_valid   <= out_valid_d;
            out_last    <= out_last_d;
            out_data    <= out_data_d;
            ru_valid_in <= ru_valid_in_d;
            ru_en       <= 1'b1;
            ru_sel_mult <= ru_sel_mult_d;
            ru_sel_mux  <= ru_sel_mux_d;
            ru_in_0     <= ru_in_0_d;
            ru_in_1     <= ru_in_1_d;
            log2_req    <= log2_req_d;
            log2_arg    <= log2_arg_d;
        end
    end

    // Element buffer. It has no reset because an aborted vector's contents are never read.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            buf_mem[wr_idx] <= wr_data;
        end
    end

endmodule

// File: doc/softmax_seq.md
SOFTMAX_SEQ -- requirements
Module: softmax_seq

Interface
REQ-001 Parameter: DEPTH, 8, maximum vector length (2..8); element buffer size.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset; synchronous and active-high.
REQ-004 Port: in_valid, in_ready, in_last  input/output/input  1 each  input element stream handshake; in_last marks the final element.
REQ-005 Port: in_data  input  16  element x_i, signed Q4.12.
REQ-006 Port: out_valid, out_ready, out_last  output/input/output  1 each  result stream handshake; out_last marks the final result.
REQ-007 Port: out_data  output  16  softmax result (RU out_1 of stage 2), Q4.12.
REQ-008 Port: ru_valid_in, ru_en, ru_sel_mult, ru_sel_mux  output  1 each  RU control.
REQ-009 Port: ru_in_0, ru_in_1  output  16  RU operands, signed Q4.12.
REQ-010 Port: ru_out_0, ru_out_1  input  16  RU results; ru_valid_out  input  1  RU result strobe.
REQ-011 Port: log2_req  output  1; log2_arg  output  16  unsigned Q4.12 sum; log2_ack  input  1; log2_res  input  16  signed Q4.12 log2(sum).

Function
REQ-012 States: IDLE, LOAD, S1_ISSUE, S1_WAIT, LOG, S2_ISSUE, S2_WAIT, OUT; one-hot or binary at implementer's choice.
REQ-013 IDLE/LOAD: in_ready=1; each in_valid&in_ready writes buf[cnt]=in_data, cnt++; IDLE->LOAD on first accepted element.
REQ-014 Max tracking: first element loads max; later elements replace max when signed in_data > max.
REQ-015 Load ends on accepted element with in_last=1 or cnt reaching DEPTH (DEPTH-th element treated as last); len latched; next state S1_ISSUE, idx=0, sum=0.
REQ-016 S1_ISSUE: drive ru_in_0=max, ru_in_1=buf[idx], ru_sel_mux=1, ru_sel_mult=1, ru_valid_in=1 for exactly one cycle; go S1_WAIT.
REQ-017 S1_WAIT: on ru_valid_out, buf[idx]=ru_out_0 (y_i), sum+=ru_out_1 (unsigned, saturate at 16'hFFFF); idx++; if idx==len-1 go LOG else S1_ISSUE.
REQ-018 Exactly one RU operation outstanding; RU latency arbitrary (>=1 cycle); ru_valid_out outside S1_WAIT/S2_WAIT ignored.
REQ-019 LOG: log2_req=1, log2_arg=sum held stable until log2_ack; on ack latch log2_res as lsum, idx=0, go S2_ISSUE.
REQ-020 S2_ISSUE: ru_in_0=lsum, ru_in_1=buf[idx], ru_sel_mux=0, ru_sel_mult=0, ru_valid_in one-cycle pulse; go S2_WAIT.
REQ-021 S2_WAIT: on ru_valid_out register out_data=ru_out_1, out_last=(idx==len-1), go OUT.
REQ-022 OUT: out_valid=1, out_data/out_last stable until out_ready; on transfer, if last go IDLE (cnt=0) else idx++, S2_ISSUE.
REQ-023 in_ready=0 in all states except IDLE/LOAD; no element accepted during processing.
REQ-024 ru_sel_* and ru_in_* hold last driven values outside ISSUE states.
REQ-025 Single-element vector: max=x_0, y_0=0, sequence otherwise identical.
REQ-026 ru_en=1 in every state except during reset.

Reset
REQ-027 On rst=1 at a clock edge: state=IDLE, cnt=idx=len=0, max=sum=lsum=0, in_ready=0 for that cycle, out_valid=0, out_last=0, out_data=0, ru_valid_in=0, ru_en=0, ru_sel_*=0, ru_in_*=0, log2_req=0, log2_arg=0.
REQ-028 Reset mid-operation (any state) aborts the vector; late ru_valid_out/log2_ack after reset ignored; buffer contents need not be cleared.

Verification
REQ-029 Two elements 0x1000, 0x2400 (in_last on 2nd), RU model latency 3 -> stage 1 issues in_0=0x2400 with in_1=0x1000 then 0x2400, sel_mux=sel_mult=1; log2_arg=sum of model out_1.
REQ-030 Stage 2 with log2_res=0x1800 -> RU issues in_0=0x1800, in_1=y_i, sel=0/0; out_data equals model out_1, out_last on 2nd result only.
REQ-031 Eight elements without in_last -> load terminates after 8th, in_ready drops next cycle, 8 results emitted.
REQ-032 out_ready held low 10 cycles in OUT -> out_valid/out_data stable, no new ru_valid_in issued.
REQ-033 Spurious ru_valid_out in LOAD and in LOG -> no state/sum change.
REQ-034 rst asserted in S1_WAIT -> next cycle IDLE, all outputs at REQ-027 values; new vector then processes correctly.
